// File: rtl/i2c_target_mem.sv
// I2C target with an internal byte memory: EEPROM-style addressed writes with
// page wrap, sequential reads, and current-address reads from the retained pointer.
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR   = 7'h2A,
  parameter int         ADDR_BYTES = 2,
  parameter int         MEM_DEPTH  = 256,
  parameter int         PAGE_SIZE  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe_o,
  output logic                         busy_o,
  output logic                         wr_valid_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [7:0]                   wr_data_o
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADR, ADR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
  } state_e;

  state_e        state_q, state_d;
  logic          scl_m_q, scl_s_q, scl_p_q, sda_m_q, sda_s_q, sda_p_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          adr_idx_q, adr_idx_d;
  logic          sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          mem_we;
  logic [7:0]    mem_q [MEM_DEPTH];

  // START/STOP need SCL high on both sides of the SDA edge, so a cycle where
  // SCL and SDA both move only yields the SCL edge.
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s_q & ~scl_p_q;
  assign scl_fall  = ~scl_s_q & scl_p_q;
  assign start_det = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

  logic [AW-1:0] ptr_inc;
  logic [7:0]    rd_cur, rd_nxt;
  assign ptr_inc = ptr_q + AW'(1);
  assign rd_cur  = mem_q[ptr_q];
  assign rd_nxt  = mem_q[ptr_inc];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      {scl_m_q, scl_s_q, scl_p_q} <= 3'b111;
      {sda_m_q, sda_s_q, sda_p_q} <= 3'b111;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      adr_idx_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      {scl_m_q, scl_s_q, scl_p_q} <= {scl_i, scl_m_q, scl_s_q};
      {sda_m_q, sda_s_q, sda_p_q} <= {sda_i, sda_m_q, sda_s_q};
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      adr_idx_q  <= adr_idx_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Memory has no reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[ptr_q] <= sh_q;
  end

  // Bytes complete on the SCL fall after the 8th rise; ACK slots finish on the
  // fall after one rise, which is when the next byte's first bit is set up.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    ptr_d      = ptr_q;
    adr_idx_d  = adr_idx_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = DEV;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        DEV, ADR, WDATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s_q};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = '0;
            sda_oe_d = 1'b1;
            if (state_q == DEV) begin
              if (sh_q[7:1] == DEV_ADDR) begin
                state_d = DEV_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end else if (state_q == ADR) begin
              state_d = ADR_ACK;
              ptr_d   = AW'({ptr_q, sh_q});
            end else begin
              state_d    = WACK;
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = sh_q;
              ptr_d      = (ptr_q & ~PMASK) | (ptr_inc & PMASK);
            end
          end
        end
        DEV_ACK, ADR_ACK, WACK: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            if (state_q == DEV_ACK && sh_q[0]) begin
              state_d  = RDATA;
              sda_oe_d = ~rd_cur[7];
              sh_d     = {rd_cur[6:0], 1'b0};
            end else if (state_q == DEV_ACK) begin
              state_d   = ADR;
              adr_idx_d = 1'b0;
            end else if (state_q == ADR_ACK && adr_idx_q != 1'(ADDR_BYTES - 1)) begin
              state_d   = ADR;
              adr_idx_d = 1'b1;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d  = RACK;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end else if (scl_fall) begin
            sda_oe_d = ~sh_q[7];
            sh_d     = {sh_q[6:0], 1'b0};
          end
        end
        RACK: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
            sh_d  = {sh_q[6:0], sda_s_q};
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d = '0;
            if (!sh_q[0]) begin
              state_d  = RDATA;
              ptr_d    = ptr_inc;
              sda_oe_d = ~rd_nxt[7];
              sh_d     = {rd_nxt[6:0], 1'b0};
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = busy_q;
  // wr_valid_o is a fire-and-forget notification: no ready, held for one cycle.
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
endmodule
